// File: rtl/cam_pixel_packer.sv
// Camera front end: packs 5 pixels per 32-bit word with SOF/EOL flags.
// Optional test-pattern source via CAM_TEST_PATTERN_EN.
module cam_pixel_packer #(
  parameter int         OVF_W   = 8,
  parameter int         LINE_W  = 10,
  parameter logic [5:0] PAD_VAL = 6'h00
) (
  input  logic              pclk,
  input  logic              rstn,
  input  logic              en,
  input  logic              vsync,
  input  logic              href,
  input  logic [5:0]        camD,
`ifdef CAM_TEST_PATTERN_EN
  input  logic              tp_sel,
`endif
  output logic [31:0]       word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_active,
  output logic [LINE_W-1:0] line_cnt,
  output logic [OVF_W-1:0]  overflow_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE
  } state_t;

  state_t          st, st_n;
  logic            vsync_q, vsync_qq;
  logic            href_q;
  logic [5:0]      camd_q;
  logic [4:0][5:0] pack, pack_n;
  logic [2:0]      cnt, cnt_n;
  logic            sof;

  logic            vs_fall, vs_rise;
  logic            start;
  logic            pix_ok;
  logic            eol;
  logic            commit;
  logic            load;
  logic            drop;
  logic [5:0]      pix;
  logic [31:0]     cword;

`ifdef CAM_TEST_PATTERN_EN
  logic [5:0]      tp_cnt;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      tp_cnt <= '0;
    end else begin
      tp_cnt <= pix_ok ? tp_cnt + 6'd1 : 6'd0;
    end
  end

  assign pix = tp_sel ? tp_cnt : camd_q;
`else
  assign pix = camd_q;
`endif

  assign vs_fall = vsync_qq & ~vsync_q;
  assign vs_rise = vsync_q & ~vsync_qq;
  assign start   = (st == WAIT_FRAME) & vs_fall;
  assign pix_ok  = (st == CAPTURE) & href_q & ~vsync_q;
  // Any cycle without an accepted pixel ends the line, including vsync rise.
  assign eol     = ~pix_ok;
  assign commit  = (cnt == 3'd5) | ((cnt != 3'd0) & eol);
  assign load    = commit & (~word_valid | word_ready);
  assign drop    = commit & word_valid & ~word_ready;

  always_comb begin
    st_n = st;
    unique case (st)
      IDLE:       if (en) st_n = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) st_n = CAPTURE;
      CAPTURE:    if (vs_rise) st_n = en ? WAIT_FRAME : IDLE;
      default:    st_n = IDLE;
    endcase
  end

  always_comb begin
    cword = {sof, eol, 30'b0};
    for (int i = 0; i < 5; i++) begin
      cword[6*i +: 6] = (3'(i) < cnt) ? pack[i] : PAD_VAL;
    end
  end

  always_comb begin
    pack_n = pack;
    cnt_n  = commit ? 3'd0 : cnt;
    if (pix_ok) begin
      pack_n[cnt_n] = pix;
      cnt_n         = cnt_n + 3'd1;
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      camd_q   <= '0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      camd_q   <= camD;
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      st           <= IDLE;
      frame_active <= 1'b0;
      pack         <= '0;
      cnt          <= '0;
      sof          <= 1'b0;
      line_cnt     <= '0;
    end else begin
      st           <= st_n;
      frame_active <= (st_n == CAPTURE);
      pack         <= pack_n;
      cnt          <= cnt_n;
      if (load) sof <= 1'b0;
      if (commit && eol && line_cnt != '1) begin
        line_cnt <= line_cnt + 1'b1;
      end
      if (start) begin
        sof      <= 1'b1;
        line_cnt <= '0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      word_data    <= '0;
      word_valid   <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      if (load) begin
        word_data  <= cword;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
      if (drop && overflow_cnt != '1) begin
        overflow_cnt <= overflow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer: table of single-line frames
// plus hand-written backpressure, enable and reset sequences.
module tb_cam_pixel_packer;

  logic        pclk;
  logic        rstn;
  logic        en;
  logic        vsync;
  logic        href;
  logic [5:0]  camD;
`ifdef CAM_TEST_PATTERN_EN
  logic        tp_sel;
`endif
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_active;
  logic [9:0]  line_cnt;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  cam_pixel_packer dut (
    .pclk         (pclk),
    .rstn         (rstn),
    .en           (en),
    .vsync        (vsync),
    .href         (href),
    .camD         (camD),
`ifdef CAM_TEST_PATTERN_EN
    .tp_sel       (tp_sel),
`endif
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .frame_active (frame_active),
    .line_cnt     (line_cnt),
    .overflow_cnt (overflow_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (rstn && word_valid && word_ready) q.push_back(word_data);
  end

  typedef struct {
    int          n;
    logic [5:0]  start;
    int          step;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic line(input int n, input logic [5:0] start, input int step);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      camD = 6'(int'(start) + i * step);
      tick();
    end
    href = 1'b0;
    camD = '0;
    repeat (6) tick();
  endtask

  function automatic logic [31:0] qat(input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    vt[0] = '{10, 6'd1,  1, 2, 32'h8510_3081, 32'h4A24_81C6};
    vt[1] = '{7,  6'h3F, 0, 2, 32'hBFFF_FFFF, 32'h4000_0FFF};
    vt[2] = '{5,  6'd1,  1, 1, 32'hC510_3081, 32'h0};
    vt[3] = '{1,  6'h2A, 0, 1, 32'hC000_002A, 32'h0};
    vt[4] = '{3,  6'd1,  1, 1, 32'hC000_3081, 32'h0};
    vt[5] = '{6,  6'h3F, 0, 2, 32'hBFFF_FFFF, 32'h4000_003F};

    rstn = 1'b0;
    en = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    camD = '0;
    word_ready = 1'b1;
`ifdef CAM_TEST_PATTERN_EN
    tp_sel = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_data", word_data, 32'd0);
    chk("rst_lines", 32'(line_cnt), 32'd0);
    chk("rst_ovf", 32'(overflow_cnt), 32'd0);
    chk("rst_active", 32'(frame_active), 32'd0);
    rstn = 1'b1;
    en = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 6; v++) begin
      q.delete();
      vs_pulse();
      line(vt[v].n, vt[v].start, vt[v].step);
      chk($sformatf("v%0d_nwords", v), 32'(q.size()), 32'(vt[v].nw));
      chk($sformatf("v%0d_w0", v), qat(0), vt[v].w0);
      if (vt[v].nw > 1) chk($sformatf("v%0d_w1", v), qat(1), vt[v].w1);
      chk($sformatf("v%0d_lines", v), 32'(line_cnt), 32'd1);
    end

    // Backpressure over a 15-pixel line.
    q.delete();
    vs_pulse();
    word_ready = 1'b0;
    line(15, 6'h3F, 0);
    chk("bp_valid", 32'(word_valid), 32'd1);
    chk("bp_held", word_data, 32'hBFFF_FFFF);
    chk("bp_ovf", 32'(overflow_cnt), 32'd2);
    chk("bp_lines", 32'(line_cnt), 32'd1);
    chk("bp_none_yet", 32'(q.size()), 32'd0);
    word_ready = 1'b1;
    repeat (4) tick();
    chk("bp_nwords", 32'(q.size()), 32'd1);
    chk("bp_word", qat(0), 32'hBFFF_FFFF);
    chk("bp_drained", 32'(word_valid), 32'd0);

    // Enable dropped mid-frame: the frame still completes.
    q.delete();
    vs_pulse();
    line(5, 6'd1, 1);
    chk("en_active", 32'(frame_active), 32'd1);
    en = 1'b0;
    repeat (3) line(5, 6'd1, 1);
    vsync = 1'b1;
    repeat (3) tick();
    chk("en_inactive", 32'(frame_active), 32'd0);
    chk("en_lines", 32'(line_cnt), 32'd4);
    chk("en_nwords", 32'(q.size()), 32'd4);
    q.delete();
    vsync = 1'b0;
    repeat (3) tick();
    line(5, 6'd1, 1);
    chk("en_ignored_words", 32'(q.size()), 32'd0);
    chk("en_ignored_active", 32'(frame_active), 32'd0);
    chk("en_ignored_lines", 32'(line_cnt), 32'd4);

    // Reset mid-line, then pixels without a frame start.
    en = 1'b1;
    tick();
    vs_pulse();
    line(5, 6'd1, 1);
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      camD = 6'h3F;
      tick();
    end
    chk("mid_valid", 32'(word_valid), 32'd1);
    chk("mid_lines", 32'(line_cnt), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(word_valid), 32'd0);
    chk("rst_mid_lines", 32'(line_cnt), 32'd0);
    chk("rst_mid_ovf", 32'(overflow_cnt), 32'd0);
    tick();
    rstn = 1'b1;
    word_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 20; i++) begin
      href = (i % 7) != 6;
      camD = 6'(i);
      tick();
    end
    href = 1'b0;
    repeat (6) tick();
    chk("post_rst_words", 32'(q.size()), 32'd0);
    chk("post_rst_active", 32'(frame_active), 32'd0);
    vs_pulse();
    line(5, 6'd1, 1);
    chk("recover_nwords", 32'(q.size()), 32'd1);
    chk("recover_word", qat(0), 32'hC510_3081);

`ifdef CAM_TEST_PATTERN_EN
    q.delete();
    tp_sel = 1'b1;
    vs_pulse();
    line(5, 6'h15, 0);
    chk("tp_nwords", 32'(q.size()), 32'd1);
    chk("tp_word", qat(0), 32'hC40C_2040);
    tp_sel = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
